// File: rtl/atc_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// atc_lookup_ctrl
//
// Lookup/fill controller for the address translation cache. It sits in front
// of an external CAM tag store: it drives the CAM search pattern, qualifies
// CAM matches with its own per-entry valid bits, and returns the physical page
// frame from a parallel data array. On a miss it requests a table walk and
// writes the walked frame into the CAM and data array. The write goes either
// to a stale (matching but invalid) slot, or else to a round-robin victim.
//
// Ports
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : invalidate all entries, reset the victim pointer
//   req_valid_i/_ready_o, req_tag_i             : request handshake, logical tag
//   rsp_valid_o/_ready_i, rsp_pa_o, rsp_hit_o,
//   rsp_fault_o                                 : response handshake and payload
//   walk_req_o, walk_tag_o                      : table walk request (level)
//   walk_ack_i, walk_pa_i, walk_fault_i         : walk completion (1-cycle pulse)
//   cam_pattern_o, cam_we_o, cam_wraddr_o       : CAM search/write port
//   cam_match_i, cam_found_i                    : CAM search result (combinational)
// -----------------------------------------------------------------------------
module atc_lookup_ctrl #(
   parameter int TAG_W = 32,
   parameter int DEPTH = 32,
   parameter int PA_W  = 24,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,

   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [TAG_W-1:0] req_tag_i,

   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [PA_W-1:0]  rsp_pa_o,
   output logic             rsp_hit_o,
   output logic             rsp_fault_o,

   output logic             walk_req_o,
   output logic [TAG_W-1:0] walk_tag_o,
   input  logic             walk_ack_i,
   input  logic [PA_W-1:0]  walk_pa_i,
   input  logic             walk_fault_i,

   output logic [TAG_W-1:0] cam_pattern_o,
   output logic             cam_we_o,
   output logic [IDX_W-1:0] cam_wraddr_o,
   input  logic [IDX_W-1:0] cam_match_i,
   input  logic             cam_found_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_WALK,
      S_FILL,
      S_RESP
   } state_e;

   state_e             state_q;
   logic [TAG_W-1:0]   tag_q;
   logic [PA_W-1:0]    pa_q;
   logic               hit_q;
   logic               fault_q;
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [PA_W-1:0]    data_q [DEPTH];
   logic [IDX_W-1:0]   victim_q, victim_d;
   logic [IDX_W-1:0]   fill_idx_q;
   logic               fill_from_victim_q;

   // Registered handshake/strobe outputs.
   logic               req_ready_q;
   logic               rsp_valid_q;
   logic               walk_req_q;
   logic               cam_we_q;

   // A CAM match only counts if this controller still considers the slot valid.
   logic               lookup_hit;
   assign lookup_hit = cam_found_i & valid_q[cam_match_i];

   // Valid bits and victim pointer: a fill sets one bit and may advance the
   // victim; a coincident flush overrides both, so a flushed fill stays invalid.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first,
      // otherwise paths that skip an assignment infer a latch.
      valid_d  = valid_q;
      victim_d = victim_q;
      if (state_q == S_FILL) begin
         valid_d[fill_idx_q] = 1'b1;
         // Reusing a stale slot does not consume a victim; the pointer wraps
         // naturally because DEPTH is a power of two.
         if (fill_from_victim_q) begin
            victim_d = victim_q + 1'b1;
         end
      end
      if (flush_i) begin
         valid_d  = '0;
         victim_d = '0;
      end
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q            <= S_IDLE;
         tag_q              <= '0;
         pa_q               <= '0;
         hit_q              <= 1'b0;
         fault_q            <= 1'b0;
         valid_q            <= '0;
         victim_q           <= '0;
         fill_idx_q         <= '0;
         fill_from_victim_q <= 1'b0;
         req_ready_q        <= 1'b1;
         rsp_valid_q        <= 1'b0;
         walk_req_q         <= 1'b0;
         cam_we_q           <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values; e.g. a LOOKUP coinciding with a
         // flush still reads the old valid bits.
         valid_q  <= valid_d;
         victim_q <= victim_d;
         case (state_q)
            S_IDLE: begin
               if (req_valid_i) begin
                  tag_q       <= req_tag_i;
                  hit_q       <= 1'b0;
                  fault_q     <= 1'b0;
                  req_ready_q <= 1'b0;
                  state_q     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (lookup_hit) begin
                  pa_q        <= data_q[cam_match_i];
                  hit_q       <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  // A matching-but-invalid slot is reused so the CAM never
                  // holds the same tag twice.
                  fill_idx_q         <= cam_found_i ? cam_match_i : victim_q;
                  fill_from_victim_q <= ~cam_found_i;
                  walk_req_q         <= 1'b1;
                  state_q            <= S_WALK;
               end
            end
            S_WALK: begin
               if (walk_ack_i) begin
                  walk_req_q <= 1'b0;
                  if (walk_fault_i) begin
                     fault_q     <= 1'b1;
                     pa_q        <= '0;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     pa_q     <= walk_pa_i;
                     cam_we_q <= 1'b1;
                     state_q  <= S_FILL;
                  end
               end
            end
            S_FILL: begin
               cam_we_q    <= 1'b0;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Data array: written in the single FILL cycle, alongside the CAM write.
   // NOTE: the storage array has no reset; an entry is only read after its
   // valid bit is set, and valid bits are reset.
   always_ff @(posedge clk_i) begin
      if (state_q == S_FILL) begin
         data_q[fill_idx_q] <= pa_q;
      end
   end

   assign req_ready_o   = req_ready_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_pa_o      = pa_q;
   assign rsp_hit_o     = hit_q;
   assign rsp_fault_o   = fault_q;
   assign walk_req_o    = walk_req_q;
   assign walk_tag_o    = tag_q;
   assign cam_pattern_o = tag_q;
   assign cam_we_o      = cam_we_q;
   assign cam_wraddr_o  = fill_idx_q;

endmodule

// File: tb/tb_atc_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atc_lookup_ctrl
//
// Self-checking bench for atc_lookup_ctrl. A small behavioural CAM answers the
// DUT's searches. A transaction-level reference model predicts hit/miss,
// frame, fault and fill slot. It holds expected CAM tags, valid flags,
// frames and a round-robin victim counter.
// -----------------------------------------------------------------------------
module tb_atc_lookup_ctrl;

   localparam int TAG_W = 32;
   localparam int DEPTH = 32;
   localparam int PA_W  = 24;
   localparam int IDX_W = 5;

   logic             clk;
   logic             rst_i;
   logic             flush_i;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [TAG_W-1:0] req_tag_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [PA_W-1:0]  rsp_pa_o;
   logic             rsp_hit_o;
   logic             rsp_fault_o;
   logic             walk_req_o;
   logic [TAG_W-1:0] walk_tag_o;
   logic             walk_ack_i;
   logic [PA_W-1:0]  walk_pa_i;
   logic             walk_fault_i;
   logic [TAG_W-1:0] cam_pattern_o;
   logic             cam_we_o;
   logic [IDX_W-1:0] cam_wraddr_o;
   logic [IDX_W-1:0] cam_match;
   logic             cam_found;

   int n_checks = 0;
   int n_errors = 0;

   atc_lookup_ctrl #(
      .TAG_W(TAG_W), .DEPTH(DEPTH), .PA_W(PA_W), .IDX_W(IDX_W)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_tag_i     (req_tag_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_pa_o      (rsp_pa_o),
      .rsp_hit_o     (rsp_hit_o),
      .rsp_fault_o   (rsp_fault_o),
      .walk_req_o    (walk_req_o),
      .walk_tag_o    (walk_tag_o),
      .walk_ack_i    (walk_ack_i),
      .walk_pa_i     (walk_pa_i),
      .walk_fault_i  (walk_fault_i),
      .cam_pattern_o (cam_pattern_o),
      .cam_we_o      (cam_we_o),
      .cam_wraddr_o  (cam_wraddr_o),
      .cam_match_i   (cam_match),
      .cam_found_i   (cam_found)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-up CAM contents: slot 0 holds a stale tag the first test looks up;
   // every other slot holds a tag outside all stimulus ranges.
   function automatic logic [TAG_W-1:0] init_tag(input int i);
      return (i == 0) ? 32'h0000_1000 : (32'hFFFF_0000 | 32'(i));
   endfunction

   // ---------------- behavioural CAM (environment) ----------------
   logic [TAG_W-1:0] cam_mem [DEPTH];
   logic             cam_load;

   always @(posedge clk) begin
      if (cam_load) begin
         for (int i = 0; i < DEPTH; i++) cam_mem[i] <= init_tag(i);
      end else if (cam_we_o) begin
         cam_mem[cam_wraddr_o] <= cam_pattern_o;
      end
   end

   always_comb begin
      cam_found = 1'b0;
      cam_match = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (cam_mem[i] == cam_pattern_o) begin
            cam_found = 1'b1;
            cam_match = IDX_W'(i);
         end
      end
   end

   // ---------------- reference model ----------------
   logic [TAG_W-1:0] exp_tag   [DEPTH];
   logic [PA_W-1:0]  exp_data  [DEPTH];
   bit               exp_valid [DEPTH];
   int               exp_victim;

   function automatic int model_find(input logic [TAG_W-1:0] tag);
      for (int i = 0; i < DEPTH; i++) if (exp_tag[i] == tag) return i;
      return -1;
   endfunction

   task automatic model_flush();
      for (int i = 0; i < DEPTH; i++) exp_valid[i] = 1'b0;
      exp_victim = 0;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete request/response transaction, starting and ending idle.
   task automatic do_req(input logic [TAG_W-1:0] tag, input logic fault, input logic [PA_W-1:0] pa,
                         input int ack_dly, input int rsp_dly, input logic flush_fill,
                         output logic o_hit, output logic [IDX_W-1:0] o_idx);
      int               idx;
      bit               exp_hit;
      int               fill_idx;
      logic [PA_W-1:0]  exp_pa;
      idx      = model_find(tag);
      exp_hit  = (idx >= 0) && exp_valid[idx];
      fill_idx = (idx >= 0) ? idx : exp_victim;
      exp_pa   = exp_hit ? exp_data[idx] : (fault ? '0 : pa);
      o_idx    = '0;

      check("req_ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1;
      req_tag_i   = tag;
      tick();                                   // edge t: accepted
      req_valid_i = 1'b0;
      req_tag_i   = $urandom;
      check("lookup_req_ready", req_ready_o, 0);
      check("lookup_rsp_valid", rsp_valid_o, 0);
      check("lookup_pattern", cam_pattern_o, tag);
      tick();                                   // edge t+1
      if (exp_hit) begin
         check("hit_rsp_valid", rsp_valid_o, 1);
         check("hit_no_walk", walk_req_o, 0);
      end else begin
         check("miss_walk_req", walk_req_o, 1);
         check("miss_walk_tag", walk_tag_o, tag);
         check("miss_rsp_valid", rsp_valid_o, 0);
         for (int d = 0; d < ack_dly; d++) begin
            tick();
            check("walk_held", walk_req_o, 1);
         end
         walk_ack_i   = 1'b1;
         walk_pa_i    = pa;
         walk_fault_i = fault;
         tick();                                // edge w
         walk_ack_i   = 1'b0;
         walk_fault_i = 1'b0;
         walk_pa_i    = PA_W'($urandom);
         check("walk_dropped", walk_req_o, 0);
         if (fault) begin
            check("fault_rsp_valid", rsp_valid_o, 1);
            check("fault_no_we", cam_we_o, 0);
         end else begin
            check("fill_we", cam_we_o, 1);
            check("fill_idx", cam_wraddr_o, fill_idx);
            check("fill_pattern", cam_pattern_o, tag);
            check("fill_rsp_valid", rsp_valid_o, 0);
            o_idx   = cam_wraddr_o;
            flush_i = flush_fill;
            tick();                             // edge w+1: write lands
            flush_i = 1'b0;
            check("post_fill_we", cam_we_o, 0);
            check("fill_rsp_valid2", rsp_valid_o, 1);
            exp_tag[fill_idx]   = tag;
            exp_data[fill_idx]  = pa;
            exp_valid[fill_idx] = 1'b1;
            if (idx < 0) exp_victim = (exp_victim + 1) % DEPTH;
            if (flush_fill) model_flush();
         end
      end

      for (int d = 0; d < rsp_dly; d++) begin
         check("bp_valid", rsp_valid_o, 1);
         check("bp_pa", rsp_pa_o, exp_pa);
         check("bp_req_ready", req_ready_o, 0);
         tick();
      end
      check("rsp_valid", rsp_valid_o, 1);
      check("rsp_pa", rsp_pa_o, exp_pa);
      check("rsp_hit", rsp_hit_o, exp_hit);
      check("rsp_fault", rsp_fault_o, !exp_hit && fault);
      check("rsp_no_we", cam_we_o, 0);
      o_hit = rsp_hit_o;
      rsp_ready_i = 1'b1;
      tick();
      rsp_ready_i = 1'b0;
      check("rsp_done", rsp_valid_o, 0);
      check("rsp_back_idle", req_ready_o, 1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic             h;
      logic [IDX_W-1:0] ix;
      int               r;

      rst_i = 1'b1; cam_load = 1'b1; flush_i = 1'b0;
      req_valid_i = 1'b0; req_tag_i = '0; rsp_ready_i = 1'b0;
      walk_ack_i = 1'b0; walk_pa_i = '0; walk_fault_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_tag[i] = init_tag(i); exp_data[i] = '0;
      end
      model_flush();
      repeat (2) @(posedge clk);
      #1;
      cam_load = 1'b0;

      // Reset values
      check("rst_req_ready", req_ready_o, 1);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_hit", rsp_hit_o, 0);
      check("rst_rsp_fault", rsp_fault_o, 0);
      check("rst_walk_req", walk_req_o, 0);
      check("rst_cam_we", cam_we_o, 0);
      check("rst_rsp_pa", rsp_pa_o, 0);
      check("rst_walk_tag", walk_tag_o, 0);
      check("rst_pattern", cam_pattern_o, 0);
      check("rst_wraddr", cam_wraddr_o, 0);
      rst_i = 1'b0;
      tick();

      // Stale slot 0 reuse, then hit on repeat
      do_req(32'h0000_1000, 1'b0, 24'h00ABC, 1, 0, 1'b0, h, ix);
      check("t1_miss", h, 0);
      check("t1_idx", ix, 0);
      do_req(32'h0000_1000, 1'b0, 24'h0, 0, 0, 1'b0, h, ix);
      check("t1_repeat_hit", h, 1);

      // 33 distinct tags: victim walks 0..31 then wraps to 0
      for (int i = 1; i <= 33; i++) begin
         do_req(32'h0000_2000 + 32'(i), 1'b0, PA_W'($urandom), $urandom_range(0, 2), 0, 1'b0, h, ix);
         if (i == 33) check("wrap_idx", ix, 0);
      end
      do_req(32'h0000_2001, 1'b0, PA_W'($urandom), 0, 0, 1'b0, h, ix);
      check("tag1_evicted", h, 0);
      do_req(32'h0000_2021, 1'b0, 24'h0, 0, 0, 1'b0, h, ix);
      check("tag33_hit", h, 1);

      // Fault: no fill, retry walks again
      do_req(32'h0000_3000, 1'b1, 24'h12345, 2, 1, 1'b0, h, ix);
      do_req(32'h0000_3000, 1'b0, 24'h00777, 0, 0, 1'b0, h, ix);
      check("fault_retry_walks", h, 0);

      // Fill 4, flush, all 4 miss and reuse their stale slots
      for (int i = 0; i < 4; i++) do_req(32'h0000_4000 + 32'(i), 1'b0, PA_W'($urandom), 0, 0, 1'b0, h, ix);
      flush_i = 1'b1; tick(); flush_i = 1'b0; model_flush();
      for (int i = 0; i < 4; i++) begin
         do_req(32'h0000_4000 + 32'(i), 1'b0, PA_W'($urandom), 1, 0, 1'b0, h, ix);
         check("post_flush_miss", h, 0);
      end
      do_req(32'h0000_4100, 1'b0, PA_W'($urandom), 0, 0, 1'b0, h, ix);
      check("new_tag_victim0", ix, 0);

      // Flush coincident with FILL: entry stays invalid
      do_req(32'h0000_5000, 1'b0, 24'h0BEEF, 0, 0, 1'b1, h, ix);
      do_req(32'h0000_5000, 1'b0, 24'h0CAFE, 0, 0, 1'b0, h, ix);
      check("flush_fill_miss", h, 0);

      // Backpressure: response held 5 cycles
      do_req(32'h0000_5000, 1'b0, 24'h0, 0, 5, 1'b0, h, ix);
      check("bp_hit", h, 1);

      // Reset mid-walk; late ack ignored
      req_valid_i = 1'b1; req_tag_i = 32'h0000_6000;
      tick();
      req_valid_i = 1'b0;
      tick();
      check("mw_walk_req", walk_req_o, 1);
      #2 rst_i = 1'b1;
      #1;
      check("mw_async_drop", walk_req_o, 0);
      check("mw_async_ready", req_ready_o, 1);
      tick();
      rst_i = 1'b0;
      model_flush();
      walk_ack_i = 1'b1; walk_pa_i = 24'h00DEAD;
      tick();
      walk_ack_i = 1'b0;
      check("late_ack_rsp", rsp_valid_o, 0);
      check("late_ack_walk", walk_req_o, 0);
      check("late_ack_we", cam_we_o, 0);
      tick();
      check("late_ack_rsp2", rsp_valid_o, 0);
      check("late_ack_ready", req_ready_o, 1);

      // Randomized traffic over a 48-tag pool (forces evictions and hits)
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 15);
         if (r == 0) begin
            flush_i = 1'b1; tick(); flush_i = 1'b0; model_flush();
         end else if (r == 1) begin
            walk_ack_i = 1'b1; walk_pa_i = PA_W'($urandom); walk_fault_i = 1'($urandom_range(0, 1));
            tick();
            walk_ack_i = 1'b0; walk_fault_i = 1'b0;
            check("stray_ack_ready", req_ready_o, 1);
            check("stray_ack_rsp", rsp_valid_o, 0);
            check("stray_ack_walk", walk_req_o, 0);
         end else begin
            do_req(32'h0000_0100 + 32'($urandom_range(0, 47)), ($urandom_range(0, 7) == 0),
                   PA_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
                   ($urandom_range(0, 9) == 0), h, ix);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
